// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state codes, ALU op codes and default width shared by alu_seq.
// Optional divide-by-zero trap selected in alu_seq by ALU_SEQ_DIV0_TRAP_EN.
package alu_seq_pkg;

   localparam int DW_DEFAULT = 18;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_CAPT = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: request/response sequencer around an external registered ALU.
// Define ALU_SEQ_DIV0_TRAP_EN to trap div/mod by zero without using the ALU.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [3:0]    req_op,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   output logic [DW-1:0] alu_datA,
   output logic [DW-1:0] alu_datB,
   output logic [3:0]    alu_ctrl,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_n,
   input  logic          alu_z,
   input  logic          alu_agtb,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_n,
   output logic          rsp_z,
   output logic          rsp_agtb,
   output logic          rsp_err
);

   state_t state;
   state_t state_nx;
   logic   accept;
   logic   trap;

   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state == ST_RESP);

`ifdef ALU_SEQ_DIV0_TRAP_EN
   assign trap = is_div_op(req_op) && (req_b == '0);
`else
   assign trap = 1'b0;
`endif

   // Next-state: IDLE -> WAIT -> CAPT -> RESP, or IDLE -> RESP on a trap
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = trap ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: state_nx = ST_CAPT;
         ST_CAPT: state_nx = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register; ready is registered so it stays low through reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_ready <= 1'b0;
      end else begin
         state     <= state_nx;
         req_ready <= (state_nx == ST_IDLE);
      end
   end

   // ALU operand/control registers, held until the next non-trap accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ctrl <= 4'd0;
         alu_datA <= '0;
         alu_datB <= '0;
      end else if (accept && !trap) begin
         alu_ctrl <= req_op;
         alu_datA <= req_a;
         alu_datB <= req_b;
      end
   end

   // Response capture: ALU result in CAPT, zeros when a trap is taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_n    <= 1'b0;
         rsp_z    <= 1'b0;
         rsp_agtb <= 1'b0;
      end else if (state == ST_CAPT) begin
         rsp_data <= alu_result;
         rsp_n    <= alu_n;
         rsp_z    <= alu_z;
         rsp_agtb <= alu_agtb;
      end else if (accept && trap) begin
         rsp_data <= '0;
         rsp_n    <= 1'b0;
         rsp_z    <= 1'b0;
         rsp_agtb <= 1'b0;
      end
   end

`ifdef ALU_SEQ_DIV0_TRAP_EN
   // Error flag decided at accept time, held through the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_err <= 1'b0;
      end else if (accept) begin
         rsp_err <= trap;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq with a registered
// ALU stand-in; expectations follow ALU_SEQ_DIV0_TRAP_EN when defined.
module tb_alu_seq;

   localparam int DW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [DW-1:0] req_a;
   logic [DW-1:0] req_b;
   logic [DW-1:0] alu_datA;
   logic [DW-1:0] alu_datB;
   logic [3:0]    alu_ctrl;
   logic [DW-1:0] alu_result;
   logic          alu_n;
   logic          alu_z;
   logic          alu_agtb;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_n;
   logic          rsp_z;
   logic          rsp_agtb;
   logic          rsp_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_seq #(.DW(DW)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op(req_op),
      .req_a(req_a),
      .req_b(req_b),
      .alu_datA(alu_datA),
      .alu_datB(alu_datB),
      .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .alu_n(alu_n),
      .alu_z(alu_z),
      .alu_agtb(alu_agtb),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_n(rsp_n),
      .rsp_z(rsp_z),
      .rsp_agtb(rsp_agtb),
      .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Registered ALU stand-in; divide/modulo by zero yield 0
   function automatic logic [DW-1:0] alu_f(input logic [3:0] c,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      case (c)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a * b;
         4'd3: return (b == '0) ? '0 : a / b;
         4'd4: return (b == '0) ? '0 : a % b;
         4'd5: return a | b;
         4'd6: return a & b;
         default: return '0;
      endcase
   endfunction

   logic [DW-1:0] fres;
   assign fres = alu_f(alu_ctrl, alu_datA, alu_datB);

   always @(posedge clk) begin
      alu_result <= fres;
      alu_n      <= fres[DW-1];
      alu_z      <= (fres == '0);
      alu_agtb   <= (alu_datA > alu_datB);
   end

   typedef struct {
      logic [3:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] data;
      logic [2:0]    flg;
      logic          err;
      int            lat;
   } vec_t;

   vec_t vt[10];

   logic [3:0]    last_op;
   logic [DW-1:0] last_a;
   logic [DW-1:0] last_b;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   task automatic wait_ready(input string nm);
      int w = 0;
      while (!req_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk({nm, ":ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_op(input vec_t v, input string nm);
      int lat;
      wait_ready(nm);
      req_valid = 1'b1;
      req_op = v.op;
      req_a = v.a;
      req_b = v.b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      if (v.err) begin
         chk({nm, ":ctrl_kept"}, {28'd0, alu_ctrl}, {28'd0, last_op});
         chk({nm, ":a_kept"}, {14'd0, alu_datA}, {14'd0, last_a});
         chk({nm, ":b_kept"}, {14'd0, alu_datB}, {14'd0, last_b});
      end else begin
         chk({nm, ":ctrl"}, {28'd0, alu_ctrl}, {28'd0, v.op});
         chk({nm, ":datA"}, {14'd0, alu_datA}, {14'd0, v.a});
         chk({nm, ":datB"}, {14'd0, alu_datB}, {14'd0, v.b});
         last_op = v.op;
         last_a = v.a;
         last_b = v.b;
      end
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk({nm, ":latency"}, lat, v.lat);
      chk({nm, ":data"}, {14'd0, rsp_data}, {14'd0, v.data});
      chk({nm, ":flags"}, {29'd0, rsp_n, rsp_z, rsp_agtb}, {29'd0, v.flg});
      chk({nm, ":err"}, {31'd0, rsp_err}, {31'd0, v.err});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({nm, ":valid_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int w;
      int seen;
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 4'd0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;

      vt[0] = '{4'd0, 18'd5, 18'd7, 18'd12, 3'b000, 1'b0, 3};
      vt[1] = '{4'd1, 18'd7, 18'd7, 18'd0, 3'b010, 1'b0, 3};
      vt[2] = '{4'd1, 18'd3, 18'd5, 18'h3FFFE, 3'b100, 1'b0, 3};
      vt[3] = '{4'd2, 18'd6, 18'd9, 18'd54, 3'b000, 1'b0, 3};
      vt[4] = '{4'd3, 18'd100, 18'd7, 18'd14, 3'b001, 1'b0, 3};
      vt[5] = '{4'd4, 18'd100, 18'd7, 18'd2, 3'b001, 1'b0, 3};
      vt[6] = '{4'd5, 18'd12, 18'd3, 18'd15, 3'b001, 1'b0, 3};
      vt[7] = '{4'd6, 18'd12, 18'd10, 18'd8, 3'b001, 1'b0, 3};
      vt[8] = '{4'd12, 18'd1, 18'd1, 18'd0, 3'b010, 1'b0, 3};
`ifdef ALU_SEQ_DIV0_TRAP_EN
      vt[9] = '{4'd3, 18'd10, 18'd0, 18'd0, 3'b000, 1'b1, 1};
`else
      vt[9] = '{4'd3, 18'd10, 18'd0, 18'd0, 3'b011, 1'b0, 3};
`endif
      last_op = 4'd0;
      last_a = '0;
      last_b = '0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst:req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst:alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("rst:rsp_data", {14'd0, rsp_data}, 32'd0);
      rst = 1'b0;
      chk("rel:ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rel:ready_high", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 10; i++) begin
         run_op(vt[i], $sformatf("vec%0d", i));
      end

      // Backpressure with a second request pending
      wait_ready("bp");
      req_valid = 1'b1;
      req_op = 4'd2;
      req_a = 18'd6;
      req_b = 18'd9;
      @(posedge clk); #1;
      req_op = 4'd0;
      req_a = 18'd1;
      req_b = 18'd1;
      w = 0;
      while (!rsp_valid && w < 20) begin
         @(posedge clk); #1; w++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp:data", {14'd0, rsp_data}, 32'd54);
         chk("bp:valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp:req_ready", {31'd0, req_ready}, 32'd0);
         chk("bp:ctrl_held", {28'd0, alu_ctrl}, 32'd2);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp:valid_drop", {31'd0, rsp_valid}, 32'd0);
      chk("bp:not_taken", {28'd0, alu_ctrl}, 32'd2);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp2:ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("bp2:datA", {14'd0, alu_datA}, 32'd1);
      w = 0;
      while (!rsp_valid && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk("bp2:data", {14'd0, rsp_data}, 32'd2);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset during WAIT
      wait_ready("rmid");
      req_valid = 1'b1;
      req_op = 4'd0;
      req_a = 18'd5;
      req_b = 18'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rmid:req_ready", {31'd0, req_ready}, 32'd0);
      chk("rmid:rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rmid:alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("rmid:alu_datA", {14'd0, alu_datA}, 32'd0);
      chk("rmid:alu_datB", {14'd0, alu_datB}, 32'd0);
      chk("rmid:rsp_data", {14'd0, rsp_data}, 32'd0);
      chk("rmid:flags", {29'd0, rsp_n, rsp_z, rsp_agtb}, 32'd0);
      chk("rmid:err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk("rmid:ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rmid:ready_high", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("rmid:no_rsp", seen, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: DW, default 18, operand/result width; SHALL match the ALU datapath width.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  block can accept a request.
REQ-006 Port: req_op  input  4  ALU control code: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 or, 6 and, 7-15 yield zero.
REQ-007 Port: req_a, req_b  input  DW  operands A and B.
REQ-008 Port: alu_datA, alu_datB  output  DW  operands driven to the ALU.
REQ-009 Port: alu_ctrl  output  4  control code driven to the ALU.
REQ-010 Port: alu_result  input  DW  registered ALU result.
REQ-011 Port: alu_n, alu_z, alu_agtb  input  1  ALU flags.
REQ-012 Port: rsp_valid  output  1  response present.
REQ-013 Port: rsp_ready  input  1  consumer accepts the response.
REQ-014 Port: rsp_data  output  DW  captured result.
REQ-015 Port: rsp_n, rsp_z, rsp_agtb  output  1  captured flags.
REQ-016 Port: rsp_err  output  1  divide-by-zero trap (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, WAIT, CAPT and RESP.
REQ-018 IDLE: req_ready=1; on req_valid the block SHALL latch req_op/req_a/req_b into the alu_ctrl/alu_datA/alu_datB registers and go to WAIT.
REQ-019 WAIT: lasts exactly 1 cycle, during which the ALU registers its result; then go to CAPT.
REQ-020 CAPT: sample alu_result, alu_n, alu_z and alu_agtb into the rsp_* registers; then go to RESP.
REQ-021 RESP: rsp_valid=1; on rsp_ready go to IDLE, with rsp_valid low on the next cycle.
REQ-022 Latency SHALL be 3 cycles from the accepting edge to rsp_valid high; throughput SHALL be at most 1 operation per 4 cycles.
REQ-023 alu_ctrl, alu_datA and alu_datB SHALL stay stable from the accepting edge until the next accept.
REQ-024 req_ready SHALL be 0 in every state other than IDLE; requests offered while busy SHALL NOT be consumed.
REQ-025 rsp_data, rsp_* flags and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-026 No arithmetic in this block; widths pass through unchanged at DW.

Reset
REQ-027 While rst=1, the FSM SHALL be IDLE and all outputs SHALL be 0, including req_ready; req_ready SHALL rise on the first clock after rst deasserts.
REQ-028 Reset mid-operation SHALL abandon the operation; rsp_valid SHALL drop immediately and no response SHALL be produced.

Configuration
REQ-029 Macro ALU_SEQ_DIV0_TRAP_EN, when defined: on accept of op 3 or 4 with req_b==0, the block SHALL skip WAIT and CAPT, go to RESP next cycle with rsp_err=1, rsp_data=0 and flags 0, and SHALL NOT change the alu_* outputs.
REQ-030 Macro undefined: no zero check is made, rsp_err SHALL be tied to 0, and every op takes the REQ-022 path.

Structure
REQ-031 Shared package alu_seq_pkg SHALL hold the state enum, the OP_ADD..OP_AND constants and the default DW.
REQ-032 No sub-module: the ALU is instantiated beside alu_seq at the top level, with clk shared.

Verification
REQ-033 Add: op 0, A=5, B=7 -> rsp_data=12, Z=0, N=0, AgtB=0, rsp_valid 3 cycles after accept.
REQ-034 Sub to zero: op 1, A=7, B=7 -> rsp_data=0, Z=1; op 1, A=3, B=5 -> rsp_data=0x3FFFE, N=1.
REQ-035 Backpressure: op 2, A=6, B=9, rsp_ready low for 5 cycles -> rsp_data=54 held stable, req_ready=0, second request not taken until handshake.
REQ-036 Div by zero: op 3, A=10, B=0 -> macro defined: rsp_err=1, rsp_data=0, 1 cycle latency; macro undefined: rsp_err=0, normal 3-cycle path.
REQ-037 Reset mid-op: assert rst during WAIT -> all outputs 0 at once, no rsp_valid afterwards, req_ready=1 one clock after release.
REQ-038 Unused op: op 12, A=1, B=1 -> rsp_data=0, Z=1.
